// File: rtl/twiddle9_pkg.sv
// rtl/twiddle9_pkg.sv - constants and Q10 twiddle table for the radix-9 twiddle stage
package twiddle9_pkg;

    localparam int TW_W    = 18;
    localparam int TW_FRAC = 10;
    localparam int N9      = 9;
    localparam int ROUND_C = 512;

    typedef logic signed [TW_W-1:0] tw_t;

    typedef struct packed {
        tw_t re;
        tw_t im;
    } tw_cplx_t;

    // W9^k in Q10; indices 9..15 are unused and read as zero
    function automatic tw_cplx_t tw_lookup(input logic [3:0] k);
        tw_cplx_t w;
        w = '0;
        case (k)
            4'd0: begin w.re =  18'sd1024; w.im =  18'sd0;    end
            4'd1: begin w.re =  18'sd784;  w.im = -18'sd659;  end
            4'd2: begin w.re =  18'sd178;  w.im = -18'sd1008; end
            4'd3: begin w.re = -18'sd512;  w.im = -18'sd887;  end
            4'd4: begin w.re = -18'sd962;  w.im = -18'sd350;  end
            4'd5: begin w.re = -18'sd962;  w.im =  18'sd350;  end
            4'd6: begin w.re = -18'sd512;  w.im =  18'sd887;  end
            4'd7: begin w.re =  18'sd178;  w.im =  18'sd1008; end
            4'd8: begin w.re =  18'sd784;  w.im =  18'sd659;  end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/twiddle9_rom.sv
// rtl/twiddle9_rom.sv - registered 9-entry twiddle table, advances only when enabled
module twiddle9_rom
    import twiddle9_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_addr,
    output tw_t        o_re,
    output tw_t        o_im
);

    tw_cplx_t w_word;

    assign w_word = tw_lookup(i_addr);

    // Output register lines up with the sample register of the first pipeline stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_re <= '0;
            o_im <= '0;
        end else if (i_en) begin
            o_re <= w_word.re;
            o_im <= w_word.im;
        end
    end

endmodule

// File: rtl/twiddle9_apply.sv
// rtl/twiddle9_apply.sv - applies W9^((r*c) mod 9) to a 9x9 frame with rounding and saturation
module twiddle9_apply
    import twiddle9_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_re,
    input  logic signed [DW-1:0] s_im,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_re,
    output logic signed [DW-1:0] m_im,
    output logic                 m_last,
    output logic                 sat_flag
);

    localparam int PW = DW + TW_W;
    localparam int SW = DW + TW_W + 1;

    localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic       w_en;
    logic       w_take;
    logic [3:0] r_r;
    logic [3:0] r_c;
    logic [3:0] r_k;
    logic [3:0] w_k_next;
    logic       w_is_last;

    logic                 r_p1_valid;
    logic                 r_p1_last;
    logic signed [DW-1:0] r_p1_re;
    logic signed [DW-1:0] r_p1_im;
    tw_t                  w_tw_re;
    tw_t                  w_tw_im;

    logic                 r_p2_valid;
    logic                 r_p2_last;
    logic signed [PW-1:0] r_p2_rr;
    logic signed [PW-1:0] r_p2_ii;
    logic signed [PW-1:0] r_p2_ri;
    logic signed [PW-1:0] r_p2_ir;

    logic signed [SW-1:0] w_sum_re;
    logic signed [SW-1:0] w_sum_im;
    logic signed [SW-1:0] w_sh_re;
    logic signed [SW-1:0] w_sh_im;
    logic                 w_clip_re;
    logic                 w_clip_im;

    // One stall signal for the whole pipeline; the input is ready whenever it moves
    assign w_en    = ~m_valid | m_ready;
    assign s_ready = w_en;
    assign w_take  = s_valid & w_en;

    // (k + r) mod 9 without widening: both operands are below 9
    assign w_k_next  = (r_k >= (4'd9 - r_r)) ? (r_k - (4'd9 - r_r)) : (r_k + r_r);
    assign w_is_last = (r_r == 4'd8) && (r_c == 4'd8);

    // Row/column/exponent counters advance on each accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= '0;
            r_c <= '0;
            r_k <= '0;
        end else if (w_take) begin
            if (r_c == 4'd8) begin
                r_c <= '0;
                r_k <= '0;
                r_r <= (r_r == 4'd8) ? 4'd0 : r_r + 4'd1;
            end else begin
                r_c <= r_c + 4'd1;
                r_k <= w_k_next;
            end
        end
    end

    twiddle9_rom u_rom (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_en),
        .i_addr (r_k),
        .o_re   (w_tw_re),
        .o_im   (w_tw_im)
    );

    // Stage 1: capture the sample alongside the table read for its exponent
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_re    <= '0;
            r_p1_im    <= '0;
        end else if (w_en) begin
            r_p1_valid <= w_take;
            r_p1_last  <= w_is_last;
            r_p1_re    <= s_re;
            r_p1_im    <= s_im;
        end
    end

    // Stage 2: the four partial products at full precision
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p2_valid <= 1'b0;
            r_p2_last  <= 1'b0;
            r_p2_rr    <= '0;
            r_p2_ii    <= '0;
            r_p2_ri    <= '0;
            r_p2_ir    <= '0;
        end else if (w_en) begin
            r_p2_valid <= r_p1_valid;
            r_p2_last  <= r_p1_last;
            r_p2_rr    <= r_p1_re * w_tw_re;
            r_p2_ii    <= r_p1_im * w_tw_im;
            r_p2_ri    <= r_p1_re * w_tw_im;
            r_p2_ir    <= r_p1_im * w_tw_re;
        end
    end

    assign w_sum_re  = SW'(r_p2_rr) - SW'(r_p2_ii);
    assign w_sum_im  = SW'(r_p2_ri) + SW'(r_p2_ir);
    assign w_sh_re   = (w_sum_re + SW'(ROUND_C)) >>> TW_FRAC;
    assign w_sh_im   = (w_sum_im + SW'(ROUND_C)) >>> TW_FRAC;
    assign w_clip_re = (w_sh_re > MAXV) || (w_sh_re < MINV);
    assign w_clip_im = (w_sh_im > MAXV) || (w_sh_im < MINV);

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
        if (v > MAXV) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (v < MINV) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return v[DW-1:0];
        end
    endfunction

    // Stage 3: round, saturate and present downstream; data holds through bubbles and stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_re     <= '0;
            m_im     <= '0;
            m_last   <= 1'b0;
            sat_flag <= 1'b0;
        end else if (w_en) begin
            m_valid <= r_p2_valid;
            m_last  <= r_p2_valid & r_p2_last;
            if (r_p2_valid) begin
                m_re <= sat_dw(w_sh_re);
                m_im <= sat_dw(w_sh_im);
                if (w_clip_re || w_clip_im) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule
